seg_spi_scanner: RTL and testbench
==================================

// Module: seg_spi_scanner
// PURPOSE
//  Upstream SPI-style frame master for the 7-segment/keypad decode stage.
//  Round-robins 4 display slots: per slot, shifts an 8-bit frame MSB-first
//  {row[1:0], screen[1:0], digit[3:0]} on mosi_o/en_o (sampled on the same clk edge),
//  then samples the returned active-low key line miso_i. Debounces 4 keys.
// PARAMETERS
//  GAP_CYCLES     1000  display hold cycles per slot after sampling (>=1)
//  SETTLE_CYCLES  4     cycles from en_o fall to miso_i sample (>=3, covers 2-flop sync)
//  DEB_COUNT      4     consecutive equal samples of a key needed to change its state (>=1)
// PORTS
//  clk          in   1   clock; also the SPI shift clock of the decode stage
//  rst_n        in   1   asynchronous active-low reset
//  enable_i     in   1   1 = scanning runs; 0 = stop after the current slot completes
//  digits_i     in   16  digit[s] = digits_i[4s+3:4s], s = 0..3
//  mosi_o       out  1   serial frame data, MSB first
//  en_o         out  1   frame enable; falling edge latches frame downstream
//  miso_i       in   1   key return, low = key of the addressed row pressed; asynchronous
//  keys_o       out  4   debounced key state, bit s = key on row s, 1 = pressed
//  key_press_o  out  1   1-cycle pulse on any debounced 0->1 key transition
//  key_idx_o    out  2   index of the key for key_press_o; holds value until next press
//  busy_o       out  1   1 whenever FSM != IDLE
// BEHAVIOUR
//  Reset (async assert, sync deassert handled upstream): en_o=0, mosi_o=0, keys_o=0,
//   key_press_o=0, key_idx_o=0, busy_o=0, slot=0, FSM=IDLE, sync flops=1 (released).
//  All outputs registered. Frame for slot s = {s[1:0], s[1:0], digit[s]}.
//  FSM: IDLE -> SHIFT when enable_i=1 (checked each cycle).
//   SHIFT: frame snapshot of digits_i taken on the entry edge; en_o=1 for exactly 8
//    cycles, cycle k (0..7) drives mosi_o=frame[7-k]. Then -> SETTLE with en_o=0, mosi_o=0.
//   SETTLE: SETTLE_CYCLES cycles counted from first cycle with en_o=0; miso_i passes a
//    2-flop synchroniser; on final cycle synced value sampled -> SAMPLE (1 cycle).
//   SAMPLE: updates debounce for key[slot]; -> GAP.
//   GAP: GAP_CYCLES cycles (display visible); then slot <= slot+1 (3 wraps to 0);
//    -> SHIFT if enable_i=1, else IDLE.
//  enable_i=0 mid-slot: current slot runs to end of GAP, then IDLE; slot still advances.
//  digits_i changes during SHIFT: ignored until next frame snapshot.
//  Debounce per key: raw = ~synced_miso. Counter cnt[s] increments when raw != keys_o[s],
//   clears when equal; when cnt reaches DEB_COUNT, keys_o[s] <= raw, cnt clears.
//   Counter width = $clog2(DEB_COUNT+1); saturates, never wraps.
//  key_press_o pulses in the cycle after SAMPLE with key_idx_o=slot when keys_o[slot] 0->1.
//   Only one key updates per SAMPLE, so simultaneous presses are impossible.
//  Release (1->0) updates keys_o without a pulse.
//  Reset mid-frame: en_o drops to 0 immediately; downstream latches a partial frame,
//   acceptable; next frame after reset begins at slot 0.
//  Slot scan period = 8 + SETTLE_CYCLES + 1 + GAP_CYCLES cycles.
// CONFIGURATION
//  SEG_SCAN_DEBOUNCE_EN defined: debounce as above.
//  Not defined: counters removed; keys_o[s] <= raw directly at SAMPLE (equivalent to
//   DEB_COUNT=1); press pulse rules unchanged; DEB_COUNT ignored.
// TESTING
//  1 reset mid-SHIFT -> en_o=0, keys_o=0, busy_o=0 in same cycle; next frame slot 0.
//  2 digits_i=16'h4321, GAP_CYCLES=2 -> frames 0x01,0x52,0xA3,0xF4 then 0x01 (wrap);
//     en_o high exactly 8 cycles each; mosi_o MSB first.
//  3 miso_i=0 only while slot 2 addressed, DEB_COUNT=4 -> keys_o=4'b0100 after 4th slot-2
//     sample; single key_press_o with key_idx_o=2; no pulse on other slots.
//  4 miso_i glitches low for 3 consecutive slot-1 samples then high -> keys_o[1] stays 0,
//     no pulse; with macro undefined -> keys_o[1]=1 after first sample and pulse.
//  5 enable_i dropped during SHIFT of slot 1 -> frame completes, SETTLE/SAMPLE/GAP run,
//     busy_o falls after GAP, next start sends slot 2.
//  6 digits_i changed mid-SHIFT -> frame on mosi_o matches value at SHIFT entry.

Source files
------------

// File: rtl/seg_spi_scanner.sv
// Round-robin frame master for the 7-segment/keypad stage: shifts one frame per slot,
// samples the returned key line and debounces it. Optional macro: SEG_SCAN_DEBOUNCE_EN.
module seg_spi_scanner #(
    parameter int GAP_CYCLES    = 1000,
    parameter int SETTLE_CYCLES = 4,
    parameter int DEB_COUNT     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic [15:0] digits_i,
    output logic        mosi_o,
    output logic        en_o,
    input  logic        miso_i,
    output logic [3:0]  keys_o,
    output logic        key_press_o,
    output logic [1:0]  key_idx_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {IDLE, SHIFT, SETTLE, SAMPLE, GAP} state_t;

    localparam int TMAX  = (GAP_CYCLES > SETTLE_CYCLES) ?
                           ((GAP_CYCLES > 8) ? GAP_CYCLES : 8) :
                           ((SETTLE_CYCLES > 8) ? SETTLE_CYCLES : 8);
    localparam int CNT_W = $clog2(TMAX);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   timer_reg, timer_next;
    logic [1:0]         slot_reg, slot_next;
    logic [7:0]         shift_reg, shift_next;
    logic               mosi_reg, mosi_next;
    logic               en_reg, en_next;
    logic               sample_reg, sample_next;
    logic               sync1_reg, sync2_reg;
    logic               press_reg;
    logic [1:0]         idx_reg;
    logic               busy_reg;
    logic [3:0]         keys_reg;
    logic [3:0]         upd;
    logic [3:0]         rise;
    logic               start;
    logic [7:0]         frame;
    logic               do_sample;
    logic               raw;

    assign do_sample = (state_reg == SAMPLE);
    assign raw       = ~sample_reg;

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        slot_next   = slot_reg;
        shift_next  = shift_reg;
        mosi_next   = 1'b0;
        en_next     = 1'b0;
        sample_next = sample_reg;
        start       = 1'b0;
        frame       = 8'h00;
        case (state_reg)
            IDLE: begin
                if (enable_i) begin
                    state_next = SHIFT;
                    start      = 1'b1;
                end
            end
            SHIFT: begin
                if (timer_reg == CNT_W'(7)) begin
                    state_next = SETTLE;
                    timer_next = '0;
                end else begin
                    en_next    = 1'b1;
                    mosi_next  = shift_reg[7];
                    shift_next = {shift_reg[6:0], 1'b0};
                    timer_next = timer_reg + 1'b1;
                end
            end
            SETTLE: begin
                if (timer_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
                    sample_next = sync2_reg;
                    state_next  = SAMPLE;
                    timer_next  = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            SAMPLE: begin
                state_next = GAP;
                timer_next = '0;
            end
            GAP: begin
                if (timer_reg == CNT_W'(GAP_CYCLES - 1)) begin
                    slot_next  = slot_reg + 1'b1;
                    timer_next = '0;
                    if (enable_i) begin
                        state_next = SHIFT;
                        start      = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // The frame snapshot is taken here, on the edge that enters SHIFT.
        if (start) begin
            frame      = {slot_next, slot_next, digits_i[{slot_next, 2'b00} +: 4]};
            en_next    = 1'b1;
            mosi_next  = frame[7];
            shift_next = {frame[6:0], 1'b0};
            timer_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            timer_reg  <= '0;
            slot_reg   <= 2'd0;
            shift_reg  <= 8'h00;
            mosi_reg   <= 1'b0;
            en_reg     <= 1'b0;
            sample_reg <= 1'b1;
            sync1_reg  <= 1'b1;
            sync2_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            press_reg  <= 1'b0;
            idx_reg    <= 2'd0;
        end else begin
            state_reg  <= state_next;
            timer_reg  <= timer_next;
            slot_reg   <= slot_next;
            shift_reg  <= shift_next;
            mosi_reg   <= mosi_next;
            en_reg     <= en_next;
            sample_reg <= sample_next;
            sync1_reg  <= miso_i;
            sync2_reg  <= sync1_reg;
            busy_reg   <= (state_next != IDLE);
            press_reg  <= |rise;
            if (|rise) begin
                idx_reg <= slot_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key
            logic key_bit_reg;
            logic hit;
            assign hit = do_sample && (slot_reg == 2'(gi));
`ifdef SEG_SCAN_DEBOUNCE_EN
            localparam int DW = $clog2(DEB_COUNT + 1);
            logic [DW-1:0] cnt_reg;
            // The state flips on the DEB_COUNT-th consecutive differing sample.
            assign upd[gi] = hit && (raw != key_bit_reg) && (cnt_reg == DW'(DEB_COUNT - 1));
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (hit) begin
                    if ((raw == key_bit_reg) || upd[gi]) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end
`else
            assign upd[gi] = hit && (raw != key_bit_reg);
`endif
            assign rise[gi]     = upd[gi] && raw;
            assign keys_reg[gi] = key_bit_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    key_bit_reg <= 1'b0;
                end else if (upd[gi]) begin
                    key_bit_reg <= raw;
                end
            end
        end
    endgenerate

    assign mosi_o      = mosi_reg;
    assign en_o        = en_reg;
    assign keys_o      = keys_reg;
    assign key_press_o = press_reg;
    assign key_idx_o   = idx_reg;
    assign busy_o      = busy_reg;

endmodule

// File: tb/tb_seg_spi_scanner.sv
// Directed bench for seg_spi_scanner: frame contents, key debounce, enable drop,
// snapshot behaviour and reset in the middle of a frame.
module tb_seg_spi_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i;
    logic [15:0] digits_i;
    logic        mosi_o;
    logic        en_o;
    logic        miso_i;
    logic [3:0]  keys_o;
    logic        key_press_o;
    logic [1:0]  key_idx_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    logic [3:0] mask;
    logic [1:0] cur_slot;
    logic       en_prev;
    logic [7:0] shreg;
    int         hi_cnt;
    int         cyc;
    int         last_rise;
    int         last_period;
    int         frame_count;
    int         press_cnt;
    logic [1:0] last_idx;
    logic [7:0] frame_log [0:1023];
    int         hi_log    [0:1023];

    seg_spi_scanner #(
        .GAP_CYCLES(2),
        .SETTLE_CYCLES(4),
        .DEB_COUNT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable_i(enable_i),
        .digits_i(digits_i),
        .mosi_o(mosi_o),
        .en_o(en_o),
        .miso_i(miso_i),
        .keys_o(keys_o),
        .key_press_o(key_press_o),
        .key_idx_o(key_idx_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Keypad model: the row addressed by the last completed frame returns low when pressed.
    assign miso_i = ~mask[cur_slot];

    initial begin
        cyc = 0; en_prev = 1'b0; shreg = 8'h00; hi_cnt = 0; last_rise = 0;
        last_period = 0; frame_count = 0; press_cnt = 0; last_idx = 2'd0; cur_slot = 2'd0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (en_o) begin
            if (!en_prev) begin
                last_period <= cyc - last_rise;
                last_rise   <= cyc;
                hi_cnt      <= 1;
            end else begin
                hi_cnt <= hi_cnt + 1;
            end
            shreg <= {shreg[6:0], mosi_o};
        end else if (en_prev) begin
            frame_log[frame_count] <= shreg;
            hi_log[frame_count]    <= hi_cnt;
            cur_slot               <= shreg[7:6];
            frame_count            <= frame_count + 1;
        end
        en_prev <= en_o;
        if (key_press_o) begin
            press_cnt <= press_cnt + 1;
            last_idx  <= key_idx_o;
        end
    end

    task automatic wait_count(input int target);
        int n = 0;
        while (frame_count < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (frame_count < target) begin
            total++; bad++;
            $display("FAIL wait_frame: frames=%0d required=%0d", frame_count, target);
        end
    endtask

    task automatic wait_slot(input logic [1:0] s);
        int  n = 0;
        int  seen = frame_count;
        bit  found = 0;
        while (!found && n < 400) begin
            @(negedge clk);
            n++;
            if (frame_count != seen) begin
                seen = frame_count;
                if (frame_log[seen-1][7:6] == s) found = 1;
            end
        end
        if (!found) begin
            total++; bad++;
            $display("FAIL wait_slot: slot %0d frame not seen required=seen", s);
        end
    endtask

    task automatic wait_rise();
        int n = 0;
        while (!en_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!en_o) begin
            total++; bad++;
            $display("FAIL wait_rise: en_o=%0b required=1", en_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable_i = 1'b0; digits_i = 16'h4321; mask = 4'b0000;
        repeat (3) @(negedge clk);
        total++; if (en_o !== 1'b0) begin bad++; $display("FAIL reset_en: got=%0b exp=0", en_o); end
        total++; if (mosi_o !== 1'b0) begin bad++; $display("FAIL reset_mosi: got=%0b exp=0", mosi_o); end
        total++; if (keys_o !== 4'b0000) begin bad++; $display("FAIL reset_keys: got=%b exp=0000", keys_o); end
        total++; if (key_press_o !== 1'b0) begin bad++; $display("FAIL reset_press: got=%0b exp=0", key_press_o); end
        total++; if (key_idx_o !== 2'd0) begin bad++; $display("FAIL reset_idx: got=%0d exp=0", key_idx_o); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_busy: got=%0b exp=0", busy_o); end
        total++; if (en_o !== 1'b0) begin bad++; $display("FAIL idle_en: got=%0b exp=0", en_o); end
        $display("test_reset: done");
    endtask

    task automatic test_frames();
        logic [7:0] exp_f [0:4];
        int base;
        exp_f[0] = 8'h01; exp_f[1] = 8'h52; exp_f[2] = 8'hA3; exp_f[3] = 8'hF4; exp_f[4] = 8'h01;
        base = frame_count;
        enable_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL run_busy: got=%0b exp=1", busy_o); end
        wait_count(base + 5);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (frame_log[base+i] !== exp_f[i]) begin
                bad++; $display("FAIL frame_%0d: got=%h exp=%h", i, frame_log[base+i], exp_f[i]);
            end
            total++;
            if (hi_log[base+i] !== 8) begin
                bad++; $display("FAIL en_len_%0d: got=%0d exp=8", i, hi_log[base+i]);
            end
            $display("test_frames: frame %0d = %h en_cycles=%0d", i, frame_log[base+i], hi_log[base+i]);
        end
        total++; if (last_period !== 15) begin bad++; $display("FAIL period: got=%0d exp=15", last_period); end
    endtask

    task automatic test_press();
        int p0 = press_cnt;
        logic [3:0] exp3;
`ifdef SEG_SCAN_DEBOUNCE_EN
        exp3 = 4'b0000;
`else
        exp3 = 4'b0100;
`endif
        mask = 4'b0100;
        for (int i = 1; i <= 4; i++) begin
            wait_slot(2'd2);
            repeat (5) @(negedge clk);
            if (i == 3) begin
                total++; if (keys_o !== exp3) begin bad++; $display("FAIL press_keys3: got=%b exp=%b", keys_o, exp3); end
            end
            $display("test_press: slot2 sample %0d keys=%b", i, keys_o);
        end
        total++; if (keys_o !== 4'b0100) begin bad++; $display("FAIL press_keys4: got=%b exp=0100", keys_o); end
        total++; if (press_cnt - p0 !== 1) begin bad++; $display("FAIL press_count: got=%0d exp=1", press_cnt - p0); end
        total++; if (last_idx !== 2'd2) begin bad++; $display("FAIL press_idx: got=%0d exp=2", last_idx); end
        total++; if (key_idx_o !== 2'd2) begin bad++; $display("FAIL press_idx_hold: got=%0d exp=2", key_idx_o); end
        mask = 4'b0000;
        for (int i = 0; i < 4; i++) wait_slot(2'd2);
        repeat (5) @(negedge clk);
        total++; if (keys_o !== 4'b0000) begin bad++; $display("FAIL release_keys: got=%b exp=0000", keys_o); end
        total++; if (press_cnt - p0 !== 1) begin bad++; $display("FAIL release_pulse: got=%0d exp=1", press_cnt - p0); end
        $display("test_press: released keys=%b", keys_o);
    endtask

    task automatic test_glitch();
        int p0;
        logic [3:0] exp_k;
        int exp_p;
`ifdef SEG_SCAN_DEBOUNCE_EN
        exp_k = 4'b0000; exp_p = 0;
`else
        exp_k = 4'b0010; exp_p = 1;
`endif
        wait_slot(2'd0);
        p0 = press_cnt;
        mask = 4'b0010;
        for (int i = 1; i <= 3; i++) begin
            wait_slot(2'd1);
            repeat (5) @(negedge clk);
            total++;
            if (keys_o !== exp_k) begin bad++; $display("FAIL glitch_keys_%0d: got=%b exp=%b", i, keys_o, exp_k); end
            $display("test_glitch: slot1 sample %0d keys=%b", i, keys_o);
        end
        mask = 4'b0000;
        total++; if (press_cnt - p0 !== exp_p) begin bad++; $display("FAIL glitch_pulses: got=%0d exp=%0d", press_cnt - p0, exp_p); end
        if (exp_p == 1) begin
            total++; if (last_idx !== 2'd1) begin bad++; $display("FAIL glitch_idx: got=%0d exp=1", last_idx); end
        end
        wait_slot(2'd1);
        repeat (5) @(negedge clk);
        total++; if (keys_o !== 4'b0000) begin bad++; $display("FAIL glitch_after: got=%b exp=0000", keys_o); end
    endtask

    task automatic test_enable_drop();
        int fc;
        wait_slot(2'd0);
        wait_rise();
        repeat (3) @(negedge clk);
        enable_i = 1'b0;
        fc = frame_count;
        wait_count(fc + 1);
        total++; if (frame_log[fc] !== 8'h52) begin bad++; $display("FAIL drop_frame: got=%h exp=52", frame_log[fc]); end
        total++; if (hi_log[fc] !== 8) begin bad++; $display("FAIL drop_len: got=%0d exp=8", hi_log[fc]); end
        repeat (5) @(negedge clk);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL drop_busy_gap: got=%0b exp=1", busy_o); end
        @(negedge clk);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL drop_busy_idle: got=%0b exp=0", busy_o); end
        fc = frame_count;
        repeat (30) @(negedge clk);
        total++; if (frame_count !== fc) begin bad++; $display("FAIL drop_quiet: frames=%0d exp=%0d", frame_count, fc); end
        enable_i = 1'b1;
        wait_count(fc + 1);
        total++; if (frame_log[fc] !== 8'hA3) begin bad++; $display("FAIL restart_frame: got=%h exp=A3", frame_log[fc]); end
        $display("test_enable_drop: restart frame=%h", frame_log[fc]);
    endtask

    task automatic test_digits_change();
        int fc;
        wait_rise();
        repeat (2) @(negedge clk);
        digits_i = 16'h9876;
        fc = frame_count;
        wait_count(fc + 1);
        total++; if (frame_log[fc] !== 8'hF4) begin bad++; $display("FAIL snap_frame: got=%h exp=F4", frame_log[fc]); end
        wait_count(fc + 2);
        total++; if (frame_log[fc+1] !== 8'h06) begin bad++; $display("FAIL new_digits: got=%h exp=06", frame_log[fc+1]); end
        $display("test_digits_change: frames=%h %h", frame_log[fc], frame_log[fc+1]);
    endtask

    task automatic test_reset_mid();
        int fc;
        mask = 4'b0001;
        for (int i = 0; i < 5; i++) wait_slot(2'd0);
        repeat (5) @(negedge clk);
        total++; if (keys_o !== 4'b0001) begin bad++; $display("FAIL pre_reset_keys: got=%b exp=0001", keys_o); end
        wait_rise();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (en_o !== 1'b0) begin bad++; $display("FAIL mid_reset_en: got=%0b exp=0", en_o); end
        total++; if (keys_o !== 4'b0000) begin bad++; $display("FAIL mid_reset_keys: got=%b exp=0000", keys_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got=%0b exp=0", busy_o); end
        total++; if (mosi_o !== 1'b0) begin bad++; $display("FAIL mid_reset_mosi: got=%0b exp=0", mosi_o); end
        mask = 4'b0000;
        repeat (3) @(negedge clk);
        fc = frame_count;
        rst_n = 1'b1;
        wait_count(fc + 1);
        total++; if (frame_log[fc] !== 8'h06) begin bad++; $display("FAIL post_reset_frame: got=%h exp=06", frame_log[fc]); end
        $display("test_reset_mid: first frame after reset=%h", frame_log[fc]);
    endtask

    initial begin
        test_reset();
        test_frames();
        test_press();
        test_glitch();
        test_enable_drop();
        test_digits_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
